app_div_seq: RTL and testbench
==============================

Name: app_div_seq

Overview:
Multi-cycle approximate unsigned/signed 16-bit divider using Mitchell logarithmic approximation, the divide-side counterpart of app_mul_top: it subtracts the characteristic and fraction instead of adding them.
Sits beside the approximate multiplier in the integer execute path, with valid/ready handshakes on both sides.
Produces a Q16.16 quotient in a scalar_t.

Parameters:
CORR_FACTOR, 15'h0200, fraction correction subtracted when APP_DIV_CORR_EN is defined (units of 2^-15).

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  operands valid
in_ready  out  1  block can accept operands (high only in IDLE)
sign  in  1  1 = operands are two's complement
dividend  in  16  dividend
divisor  in  16  divisor
out_valid  out  1  result valid, held until accepted
out_ready  in  1  consumer accepts result
quotient  out  32 (scalar_t)  Q16.16 quotient, two's complement when sign=1
div_by_zero  out  1  divisor was zero, valid with out_valid

Behaviour:
- Reset (asynchronous, any state): state=IDLE, in_ready=1, out_valid=0, quotient=0, div_by_zero=0, all internal registers=0.
- FSM states: IDLE -> NORM -> SUB -> SCALE -> DONE -> IDLE.
- IDLE: in_ready=1. When in_valid=1, capture sign/dividend/divisor and go to NORM. No other state accepts input.
- NORM:
  - Magnitudes: |x| when sign=1 and x[15]=1, otherwise x. 16'h8000 magnitude is treated as unsigned 32768.
  - Leading-one positions ka, kb (0..15).
  - 15-bit fractions fa, fb are the bits below the leading one, left-aligned.
  - Result negative flag neg = sign & (dividend[15] ^ divisor[15]).
- SUB:
  - e = ka - kb, signed 5 bits (-15..15).
  - d = fa - fb, 16 bits.
  - No borrow: mant = {1'b1, d[14:0]}, exponent e.
  - Borrow: mant = {1'b1, d[14:0]}, exponent e-1 (the 2+fa-fb form).
- SCALE:
  - s = exponent + 1, range -15..16.
  - s >= 0: mag = {16'b0, mant} << s. s < 0: mag = mant >> -s, truncating.
  - quotient = neg ? -mag : mag.
- DONE: out_valid=1. quotient and div_by_zero are stable while out_ready=0. On out_ready=1, go to IDLE; out_valid drops the next cycle.
- Latency: operands accepted at edge N give out_valid=1 after edge N+3. Minimum initiation interval is 5 cycles.
- Special cases keep the uniform latency:
  - divisor==0: div_by_zero=1. Unsigned: quotient=32'hFFFF_FFFF. Signed: 32'h7FFF_FFFF for a non-negative dividend, 32'h8000_0000 for a negative one.
  - dividend==0 with divisor!=0: quotient=0.
- in_valid while not in IDLE is ignored (in_ready=0). Operands must be held by the source until the accepting edge.
- Reset asserted mid-operation discards the operation; no partial output.

Optional Feature:
APP_DIV_CORR_EN:
- Defined: in SUB, the 15-bit fraction field becomes max(d[14:0] - CORR_FACTOR, 0) before forming mant. This reduces Mitchell's positive error. Special cases are unaffected.
- Undefined: no correction logic; the fraction field is d[14:0] exactly.

Decomposition:
- defines package additions: app_div_state_t enum (IDLE, NORM, SUB, SCALE, DONE); constant APP_DIV_FRAC_W=15; Q16.16 saturation constants.
- One sub-module, app_lod16: 16-bit leading-one detector plus left-aligned fraction extractor. Instantiated twice here and reusable by app_mul_top.

Test Plan:
- Unsigned 100/10 -> quotient 32'h000A_8000 (10.5) at edge N+3; div_by_zero=0. With APP_DIV_CORR_EN -> 32'h000A_6000.
- Unsigned 10/100, borrow path -> 32'h0000_1B00. Unsigned 64/8 -> 32'h0008_0000. Extremes: 65535/1 -> 32'hFFFF_0000; 1/65535 -> 32'h0000_0001.
- sign=1, dividend=-100 (16'hFF9C), divisor=10 -> 32'hFFF5_8000. sign=0 with the same bits -> positive result.
- Divisor 0: unsigned 5/0 -> 32'hFFFF_FFFF, div_by_zero=1. Signed -5/0 -> 32'h8000_0000. 0/7 -> 0.
- Handshakes:
  - Hold out_ready=0 for 10 cycles: out_valid and quotient stable, in_ready=0, new in_valid ignored.
  - Raise out_ready: IDLE next cycle, back-to-back operation accepted.
- Assert reset_n=0 asynchronously while in SUB -> out_valid=0, in_ready=1 immediately. No stale result appears after release.

Source files
------------

// File: rtl/app_div_seq_pkg.sv
// Shared types and constants for the Mitchell approximate divider (app_div_seq).
package app_div_seq_pkg;
  typedef logic [31:0] scalar_t;

  typedef enum logic [2:0] {IDLE, NORM, SUB, SCALE, DONE} app_div_state_t;

  localparam int APP_DIV_FRAC_W = 15;

  // Q16.16 saturation results used for divide-by-zero
  localparam scalar_t Q_SAT_UMAX = 32'hFFFF_FFFF;
  localparam scalar_t Q_SAT_SMAX = 32'h7FFF_FFFF;
  localparam scalar_t Q_SAT_SMIN = 32'h8000_0000;

  typedef struct packed {
    logic        sign;
    logic [15:0] dividend;
    logic [15:0] divisor;
  } app_div_req_t;
endpackage

// File: rtl/app_lod16.sv
// 16-bit leading-one detector with left-aligned fraction (bits below the leading one).
module app_lod16
  import app_div_seq_pkg::*;
(
  input  logic [15:0]               val,
  output logic [3:0]                pos,
  output logic [APP_DIV_FRAC_W-1:0] frac
);
  always_comb begin
    pos = '0;
    for (int i = 0; i < 16; i++)
      if (val[i]) pos = 4'(i);
  end

  // shifting the leading one into bit 15 leaves the fraction in bits 14:0
  assign frac = APP_DIV_FRAC_W'(val << (4'd15 - pos));
endmodule

// File: rtl/app_div_seq.sv
// Multi-cycle Mitchell-log approximate 16-bit divider, Q16.16 quotient.
// Define APP_DIV_CORR_EN to subtract CORR_FACTOR from the difference fraction.
module app_div_seq
  import app_div_seq_pkg::*;
`ifdef APP_DIV_CORR_EN
#(
  parameter logic [APP_DIV_FRAC_W-1:0] CORR_FACTOR = 15'h0200
)
`endif
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output scalar_t     quotient,
  output logic        div_by_zero
);
  localparam int NUM_OPS = 2;

  app_div_state_t state, state_nxt;
  app_div_req_t   req_q;

  logic [NUM_OPS-1:0][15:0]               mag;
  logic [NUM_OPS-1:0][3:0]                pos;
  logic [NUM_OPS-1:0][APP_DIV_FRAC_W-1:0] frac;

  logic [3:0]                ka_q, kb_q;
  logic [APP_DIV_FRAC_W-1:0] fa_q, fb_q;
  logic                      neg_q;
  logic signed [5:0]         exp_q;
  logic [15:0]               mant_q;
  scalar_t                   quotient_q;
  logic                      dz_q;

  // operand magnitudes; 16'h8000 negates to itself and reads as 32768
  assign mag[0] = (req_q.sign & req_q.dividend[15]) ? -req_q.dividend : req_q.dividend;
  assign mag[1] = (req_q.sign & req_q.divisor[15])  ? -req_q.divisor  : req_q.divisor;

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_lod
    app_lod16 u_lod (.val(mag[g]), .pos(pos[g]), .frac(frac[g]));
  end

  logic [15:0]               diff;
  logic signed [5:0]         e_raw, e_adj;
  logic [APP_DIV_FRAC_W-1:0] frac_sub;

  assign diff  = {1'b0, fa_q} - {1'b0, fb_q};
  assign e_raw = $signed({2'b0, ka_q}) - $signed({2'b0, kb_q});
  // a borrow means the mantissa is 2+fa-fb, i.e. one octave lower
  assign e_adj = diff[15] ? e_raw - 6'sd1 : e_raw;

`ifdef APP_DIV_CORR_EN
  assign frac_sub = (diff[APP_DIV_FRAC_W-1:0] > CORR_FACTOR) ?
                    diff[APP_DIV_FRAC_W-1:0] - CORR_FACTOR : '0;
`else
  assign frac_sub = diff[APP_DIV_FRAC_W-1:0];
`endif

  logic signed [5:0] shamt;
  logic [4:0]        rsh;
  scalar_t           mag_q16, q_norm, q_res;
  logic              dz_res;

  assign shamt = exp_q + 6'sd1;
  assign rsh   = 5'(-shamt);

  always_comb begin
    mag_q16 = shamt[5] ? ({16'b0, mant_q} >> rsh) : ({16'b0, mant_q} << shamt[4:0]);
    q_norm  = neg_q ? -mag_q16 : mag_q16;
    dz_res  = (req_q.divisor == '0);
    q_res   = q_norm;
    if (dz_res)
      q_res = !req_q.sign ? Q_SAT_UMAX : (req_q.dividend[15] ? Q_SAT_SMIN : Q_SAT_SMAX);
    else if (req_q.dividend == '0)
      q_res = '0;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = NORM;
      end
      NORM:  state_nxt = SUB;
      SUB:   state_nxt = SCALE;
      SCALE: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q      <= '0;
      ka_q       <= '0;
      kb_q       <= '0;
      fa_q       <= '0;
      fb_q       <= '0;
      neg_q      <= 1'b0;
      exp_q      <= '0;
      mant_q     <= '0;
      quotient_q <= '0;
      dz_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) req_q <= '{sign: sign, dividend: dividend, divisor: divisor};
        NORM: begin
          ka_q  <= pos[0];
          kb_q  <= pos[1];
          fa_q  <= frac[0];
          fb_q  <= frac[1];
          neg_q <= req_q.sign & (req_q.dividend[15] ^ req_q.divisor[15]);
        end
        SUB: begin
          exp_q  <= e_adj;
          mant_q <= {1'b1, frac_sub};
        end
        SCALE: begin
          quotient_q <= q_res;
          dz_q       <= dz_res;
        end
        default: ;
      endcase
    end
  end

  assign quotient    = quotient_q;
  assign div_by_zero = dz_q;
endmodule

// File: tb/tb_app_div_seq.sv
// Self-checking bench for app_div_seq: directed table, handshake/reset sequences, random vs model.
module tb_app_div_seq;
  import app_div_seq_pkg::*;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        in_valid = 1'b0, sign = 1'b0, out_ready = 1'b0;
  logic [15:0] dividend = '0, divisor = '0;
  logic        in_ready, out_valid, div_by_zero;
  scalar_t     quotient;
  int          tests = 0, fails = 0;

  always #5 clk = ~clk;

  app_div_seq dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .sign(sign), .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .div_by_zero(div_by_zero)
  );

  typedef struct packed {
    logic        s;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] q;
    logic [31:0] qc;
    logic        dz;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Mitchell division from the log-domain definition: log2 q ~= (ka+fa) - (kb+fb)
  function automatic void model(input logic s, input logic [15:0] a, input logic [15:0] b,
                                output logic [31:0] q, output logic dz);
    int ma, mb, ka, kb, fa, fb, l, e, f;
    longint m;
    dz = (b == 0);
    if (dz) begin
      q = !s ? 32'hFFFF_FFFF : (a[15] ? 32'h8000_0000 : 32'h7FFF_FFFF);
      return;
    end
    ma = (s && a[15]) ? 65536 - int'(a) : int'(a);
    mb = (s && b[15]) ? 65536 - int'(b) : int'(b);
    if (ma == 0) begin
      q = '0;
      return;
    end
    ka = $clog2(ma + 1) - 1;
    kb = $clog2(mb + 1) - 1;
    fa = ((ma - (1 << ka)) << 15) >> ka;
    fb = ((mb - (1 << kb)) << 15) >> kb;
    l  = (ka * 32768 + fa) - (kb * 32768 + fb);
    e  = l >>> 15;
    f  = l & 32'h7FFF;
`ifdef APP_DIV_CORR_EN
    f = (f > 32'h200) ? f - 32'h200 : 0;
`endif
    m = longint'(32768 + f);
    m = (e + 1 >= 0) ? (m << (e + 1)) : (m >> (-(e + 1)));
    if (s && (a[15] ^ b[15])) m = -m;
    q = m[31:0];
  endfunction

  task automatic run_op(input logic s, input logic [15:0] a, input logic [15:0] b,
                        output logic [31:0] q, output logic dz, output int lat);
    @(negedge clk);
    sign = s; dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    q  = quotient;
    dz = div_by_zero;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q, exp_q;
    logic        dz, exp_dz, stale;
    logic [15:0] ra, rb;
    logic        rs;
    int          lat;

    tbl[0]  = '{1'b0, 16'd100,   16'd10,    32'h000A_8000, 32'h000A_6000, 1'b0};
    tbl[1]  = '{1'b0, 16'd10,    16'd100,   32'h0000_1B00, 32'h0000_1AC0, 1'b0};
    tbl[2]  = '{1'b0, 16'd64,    16'd8,     32'h0008_0000, 32'h0008_0000, 1'b0};
    tbl[3]  = '{1'b0, 16'hFFFF,  16'd1,     32'hFFFF_0000, 32'hFDFF_0000, 1'b0};
    tbl[4]  = '{1'b0, 16'd1,     16'hFFFF,  32'h0000_0001, 32'h0000_0001, 1'b0};
    tbl[5]  = '{1'b1, 16'hFF9C,  16'd10,    32'hFFF5_8000, 32'hFFF5_A000, 1'b0};
    tbl[6]  = '{1'b0, 16'hFF9C,  16'd10,    32'h1BF3_8000, 32'h1BB3_8000, 1'b0};
    tbl[7]  = '{1'b0, 16'd5,     16'd0,     32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};
    tbl[8]  = '{1'b1, 16'hFFFB,  16'd0,     32'h8000_0000, 32'h8000_0000, 1'b1};
    tbl[9]  = '{1'b1, 16'd5,     16'd0,     32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1};
    tbl[10] = '{1'b0, 16'd0,     16'd7,     32'h0000_0000, 32'h0000_0000, 1'b0};

    #1;
    check("reset_in_ready",  32'(in_ready),    32'd1);
    check("reset_out_valid", 32'(out_valid),   32'd0);
    check("reset_quotient",  quotient,         32'd0);
    check("reset_dbz",       32'(div_by_zero), 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op(tbl[i].s, tbl[i].a, tbl[i].b, q, dz, lat);
`ifdef APP_DIV_CORR_EN
      exp_q = tbl[i].qc;
`else
      exp_q = tbl[i].q;
`endif
      check($sformatf("vec%0d_quotient", i), q, exp_q);
      check($sformatf("vec%0d_dbz", i), 32'(dz), 32'(tbl[i].dz));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
    end

    // result held under backpressure while new input is ignored
    model(1'b0, 16'd100, 16'd10, exp_q, exp_dz);
    @(negedge clk);
    sign = 1'b0; dividend = 16'd100; divisor = 16'd10; in_valid = 1'b1;
    @(posedge clk); #1;
    dividend = 16'd7; divisor = 16'd3;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("hold_latency", 32'(lat), 32'd3);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d_out_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d_quotient", c), quotient, exp_q);
      check($sformatf("hold%0d_in_ready", c), 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    dividend = 16'd64; divisor = 16'd8; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_in_ready",  32'(in_ready),  32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_latency",  32'(lat), 32'd3);
    check("b2b_quotient", quotient, 32'h0008_0000);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;

    // asynchronous reset while the operation sits in SUB
    @(negedge clk);
    sign = 1'b0; dividend = 16'd1000; divisor = 16'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_quotient",  quotient,       32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    stale = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) stale = 1'b1;
    end
    check("midrst_no_stale", 32'(stale), 32'd0);

    for (int n = 0; n < 150; n++) begin
      rs = 1'($urandom_range(0, 1));
      ra = 16'($urandom) >> $urandom_range(0, 15);
      rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 15) == 0) ra = 16'd0;
      model(rs, ra, rb, exp_q, exp_dz);
      run_op(rs, ra, rb, q, dz, lat);
      check($sformatf("rnd%0d_q s=%0d a=%h b=%h", n, rs, ra, rb), q, exp_q);
      check($sformatf("rnd%0d_dbz", n), 32'(dz), 32'(exp_dz));
      check($sformatf("rnd%0d_latency", n), 32'(lat), 32'd3);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
